// File: rtl/tetris_pkg.sv
// Shared types, board dimensions and tetromino shape table for the Tetris engine.
package tetris_pkg;

   localparam int ROWS      = 20;
   localparam int COLS      = 10;
   localparam int SPAWN_ROW = 19;
   localparam int SPAWN_COL = 3;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SPAWN, ST_FALL, ST_LAND, ST_CLEAR, ST_GAMEOVER
   } state_t;

   typedef enum logic [2:0] {
      P_I, P_O, P_T, P_S, P_Z, P_J, P_L
   } piece_t;

   typedef logic [ROWS-1:0][COLS-1:0] board_t;
   typedef logic signed [5:0]         coord_t;

   // Indexed [type][rotation]; bit r*4+c = box row r (counted downward), box column c.
   localparam logic [15:0] SHAPES [7][4] = '{
      '{16'h000F, 16'h4444, 16'h00F0, 16'h2222},
      '{16'h0066, 16'h0066, 16'h0066, 16'h0066},
      '{16'h0027, 16'h0232, 16'h0072, 16'h0262},
      '{16'h0036, 16'h0231, 16'h0036, 16'h0231},
      '{16'h0063, 16'h0264, 16'h0063, 16'h0264},
      '{16'h0047, 16'h0322, 16'h0071, 16'h0226},
      '{16'h0017, 16'h0223, 16'h0074, 16'h0622}
   };

   function automatic logic [15:0] shape_of(input piece_t p, input logic [1:0] rot);
      return SHAPES[p][rot];
   endfunction

endpackage

// File: rtl/tetris_collide.sv
// Places a piece on the board: flags off-board or stack overlap and returns its cell mask.
// Purely combinational, zero latency, no flow control.
module tetris_collide
   import tetris_pkg::*;
(
   input  board_t     stack_i,
   input  piece_t     type_i,
   input  logic [1:0] rot_i,
   input  coord_t     row_i,
   input  coord_t     col_i,
   output logic       hit_o,
   output board_t     mask_o
);

   logic [15:0] shape;

   always_comb begin
      coord_t pr;
      coord_t pc;
      shape  = shape_of(type_i, rot_i);
      hit_o  = 1'b0;
      mask_o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            pr = row_i - coord_t'(r);
            pc = col_i + coord_t'(c);
            if (shape[r*4+c]) begin
               // Rows above the top are treated as blocked too, which also keeps the index in range.
               if (pr < 0 || pc < 0 || pc > coord_t'(COLS-1) || pr > coord_t'(ROWS-1)) begin
                  hit_o = 1'b1;
               end else begin
                  mask_o[pr[4:0]][pc[3:0]] = 1'b1;
                  if (stack_i[pr[4:0]][pc[3:0]]) hit_o = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/tetris_fsm.sv
// Tetris engine: 20x10 stack plus one falling piece, moves, gravity, line clear, score, game over.
// Moves visible one edge after the pulse; CLEAR removes one full row per cycle; no backpressure.
module tetris_fsm
   import tetris_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              onehuzz,
   input  logic              en_newgame,
   input  logic              start_i,
   input  logic              left_i,
   input  logic              right_i,
   input  logic              rotate_r,
   input  logic              rotate_l,
   input  logic              speed_up_i,
   output logic [19:0][9:0]  display_array,
   output logic              gameover,
   output logic [7:0]        score,
   output logic              speed_mode_o
);

   state_t     state_q, state_d;
   board_t     stack_q, stack_d;
   piece_t     type_q, type_d;
   piece_t     cnt_q, cnt_d;
   logic [1:0] rot_q, rot_d;
   coord_t     row_q, row_d;
   coord_t     col_q, col_d;
   logic [7:0] score_q, score_d;
   logic       gover_q, gover_d;
   logic       speed_q;

   logic       cur_hit, t_hit;
   board_t     cur_mask, t_mask;
   logic [1:0] t_rot;
   coord_t     t_row, t_col;
   logic       drop, act, load;
   logic       full_vld;
   logic [4:0] full_idx;
   board_t     shifted;

   tetris_collide u_cur (
      .stack_i (stack_q),
      .type_i  (type_q),
      .rot_i   (rot_q),
      .row_i   (row_q),
      .col_i   (col_q),
      .hit_o   (cur_hit),
      .mask_o  (cur_mask)
   );

   tetris_collide u_trial (
      .stack_i (stack_q),
      .type_i  (type_q),
      .rot_i   (t_rot),
      .row_i   (t_row),
      .col_i   (t_col),
      .hit_o   (t_hit),
      .mask_o  (t_mask)
   );

   assign drop    = speed_q | onehuzz;
   assign act     = rotate_r | rotate_l | left_i | right_i;
   assign shifted = {{COLS{1'b0}}, stack_q[ROWS-1:1]};

   // Outside FALL the trial port rests on the current piece, so LAND merges its mask.
   always_comb begin
      t_rot = rot_q;
      t_row = row_q;
      t_col = col_q;
      if (state_q == ST_FALL) begin
         if (drop)          t_row = row_q - coord_t'(1);
         else if (rotate_r) t_rot = rot_q + 2'd1;
         else if (rotate_l) t_rot = rot_q - 2'd1;
         else if (left_i)   t_col = col_q - coord_t'(1);
         else if (right_i)  t_col = col_q + coord_t'(1);
      end
   end

   always_comb begin
      full_vld = 1'b0;
      full_idx = '0;
      for (int r = ROWS-1; r >= 0; r--) begin
         if (&stack_q[r]) begin
            full_vld = 1'b1;
            full_idx = 5'(r);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      stack_d = stack_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      rot_d   = rot_q;
      row_d   = row_q;
      col_d   = col_q;
      score_d = score_q;
      gover_d = gover_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stack_d = '0;
            score_d = '0;
            rot_d   = '0;
            row_d   = '0;
            col_d   = '0;
            if (start_i) begin
               state_d = ST_SPAWN;
               load    = 1'b1;
            end
         end
         ST_SPAWN: begin
            if (cur_hit) begin
               state_d = ST_GAMEOVER;
               gover_d = 1'b1;
            end else begin
               state_d = ST_FALL;
            end
         end
         ST_FALL: begin
            if (drop) begin
               if (t_hit) state_d = ST_LAND;
               else       row_d   = t_row;
            end else if (act && !t_hit) begin
               rot_d = t_rot;
               col_d = t_col;
            end
         end
         ST_LAND: begin
            stack_d = stack_q | t_mask;
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (full_vld) begin
               for (int r = 0; r < ROWS; r++) begin
                  if (5'(r) >= full_idx) stack_d[r] = shifted[r];
               end
               score_d = score_q + {7'd0, (score_q != 8'hFF)};
            end else begin
               state_d = ST_SPAWN;
               load    = 1'b1;
            end
         end
         ST_GAMEOVER: begin
            if (en_newgame) begin
               state_d = ST_IDLE;
               gover_d = 1'b0;
               stack_d = '0;
               score_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         type_d = cnt_q;
         cnt_d  = (cnt_q == P_L) ? P_I : piece_t'(cnt_q + 3'd1);
         rot_d  = '0;
         row_d  = coord_t'(SPAWN_ROW);
         col_d  = coord_t'(SPAWN_COL);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         stack_q <= '0;
         type_q  <= P_I;
         cnt_q   <= P_O;
         rot_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         score_q <= '0;
         gover_q <= 1'b0;
         speed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stack_q <= stack_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         rot_q   <= rot_d;
         row_q   <= row_d;
         col_q   <= col_d;
         score_q <= score_d;
         gover_q <= gover_d;
         speed_q <= speed_up_i;
      end
   end

   assign display_array = stack_q | ((state_q == ST_FALL) ? cur_mask : board_t'('0));
   assign gameover      = gover_q;
   assign score         = score_q;
   assign speed_mode_o  = speed_q;

endmodule

// File: tb/tb_tetris_fsm.sv
// Directed bench for tetris_fsm: moves, gravity, landing, line clear, game over, new game.
module tb_tetris_fsm;

   localparam int P_START = 0, P_LEFT = 1, P_RIGHT = 2, P_ROTR = 3, P_ROTL = 4, P_TICK = 5, P_NEW = 6;

   logic clk = 1'b0;
   logic reset, onehuzz, en_newgame, start_i, left_i, right_i, rotate_r, rotate_l, speed_up_i;
   logic [19:0][9:0] display_array;
   logic gameover, speed_mode_o;
   logic [7:0] score;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tetris_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .onehuzz       (onehuzz),
      .en_newgame    (en_newgame),
      .start_i       (start_i),
      .left_i        (left_i),
      .right_i       (right_i),
      .rotate_r      (rotate_r),
      .rotate_l      (rotate_l),
      .speed_up_i    (speed_up_i),
      .display_array (display_array),
      .gameover      (gameover),
      .score         (score),
      .speed_mode_o  (speed_mode_o)
   );

   task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [199:0] put(input logic [199:0] b, input int row, input int col);
      logic [199:0] t;
      t = b;
      t[row*10+col] = 1'b1;
      return t;
   endfunction

   function automatic logic [199:0] o_at(input int top, input int left);
      logic [199:0] b;
      b = '0;
      b = put(b, top, left);
      b = put(b, top, left+1);
      b = put(b, top-1, left);
      b = put(b, top-1, left+1);
      return b;
   endfunction

   function automatic logic [199:0] t0_at(input int top, input int left);
      logic [199:0] b;
      b = '0;
      b = put(b, top, left);
      b = put(b, top, left+1);
      b = put(b, top, left+2);
      b = put(b, top-1, left+1);
      return b;
   endfunction

   task automatic pulse(input int which);
      case (which)
         P_START: start_i    = 1'b1;
         P_LEFT:  left_i     = 1'b1;
         P_RIGHT: right_i    = 1'b1;
         P_ROTR:  rotate_r   = 1'b1;
         P_ROTL:  rotate_l   = 1'b1;
         P_TICK:  onehuzz    = 1'b1;
         default: en_newgame = 1'b1;
      endcase
      @(negedge clk);
      {start_i, left_i, right_i, rotate_r, rotate_l, onehuzz, en_newgame} = '0;
   endtask

   task automatic restart;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      pulse(P_START);
      @(negedge clk);
   endtask

   logic [199:0] pre, sides, t_rot1;

   initial begin
      {onehuzz, en_newgame, start_i, left_i, right_i, rotate_r, rotate_l, speed_up_i} = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_display", display_array, '0);
      chk("rst_score", score, '0);
      chk("rst_gameover", gameover, '0);
      chk("rst_speed", speed_mode_o, '0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_display", display_array, '0);
      chk("idle_score", score, '0);
      chk("idle_gameover", gameover, '0);

      // Spawn timing and a stationary O piece.
      pulse(P_START);
      chk("spawn_hidden", display_array, '0);
      @(negedge clk);
      chk("spawn_visible", display_array, o_at(19, 4));
      repeat (20) @(negedge clk);
      chk("o_hold_20", display_array, o_at(19, 4));

      repeat (4) pulse(P_LEFT);
      chk("left_x4", display_array, o_at(19, 0));
      pulse(P_LEFT);
      chk("left_wall", display_array, o_at(19, 0));
      repeat (10) pulse(P_RIGHT);
      chk("right_wall", display_array, o_at(19, 8));

      reset = 1'b0;
      #1;
      chk("midgame_reset", display_array, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Gravity to the floor, landing, and the next (T) spawn.
      pulse(P_START);
      @(negedge clk);
      repeat (18) pulse(P_TICK);
      chk("drop_18", display_array, o_at(1, 4));
      pulse(P_TICK);
      chk("land_hidden", display_array, '0);
      @(negedge clk);
      chk("land_merged", display_array, o_at(1, 4));
      repeat (2) @(negedge clk);
      chk("t_spawn", display_array, o_at(1, 4) | t0_at(19, 3));

      rotate_r = 1'b1;
      left_i   = 1'b1;
      @(negedge clk);
      {rotate_r, left_i} = '0;
      t_rot1 = put(put(put(put('0, 19, 4), 18, 3), 18, 4), 17, 4);
      chk("rotr_over_left", display_array, o_at(1, 4) | t_rot1);
      pulse(P_ROTL);
      chk("rotl_back", display_array, o_at(1, 4) | t0_at(19, 3));
      onehuzz = 1'b1;
      left_i  = 1'b1;
      @(negedge clk);
      {onehuzz, left_i} = '0;
      chk("drop_over_left", display_array, o_at(1, 4) | t0_at(18, 3));

      // Two nearly full rows completed by the O: double clear.
      restart();
      pre = '0;
      pre[9:0]   = 10'h3CF;
      pre[19:10] = 10'h3CF;
      force dut.stack_q = pre;
      @(negedge clk);
      release dut.stack_q;
      chk("preload", display_array, pre | o_at(19, 4));
      repeat (18) pulse(P_TICK);
      pulse(P_TICK);
      repeat (2) @(negedge clk);
      chk("clear_one_display", display_array, {190'd0, 10'h3FF});
      chk("clear_one_score", score, 8'd1);
      repeat (3) @(negedge clk);
      chk("clear_two_display", display_array, t0_at(19, 3));
      chk("clear_two_score", score, 8'd2);

      // Fast drop stacks pieces at the spawn columns until a spawn collides.
      restart();
      speed_up_i = 1'b1;
      @(negedge clk);
      chk("speed_mode", speed_mode_o, 1'b1);
      for (int i = 0; i < 3000 && !gameover; i++) @(negedge clk);
      chk("gameover", gameover, 1'b1);
      chk("gameover_score", score, '0);
      sides = '0;
      for (int r = 0; r < 20; r++) begin
         for (int c = 0; c < 10; c++) begin
            if (c < 3 || c > 6) sides[r*10+c] = 1'b1;
         end
      end
      chk("gameover_sides", display_array & sides, '0);
      chk("gameover_top", |display_array[19], 1'b1);
      speed_up_i = 1'b0;
      pulse(P_START);
      pulse(P_LEFT);
      pulse(P_TICK);
      repeat (3) @(negedge clk);
      chk("gameover_held", gameover, 1'b1);
      chk("gameover_frozen_sides", display_array & sides, '0);
      pulse(P_NEW);
      @(negedge clk);
      chk("newgame_display", display_array, '0);
      chk("newgame_score", score, '0);
      chk("newgame_gameover", gameover, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/tetris_fsm.md
# tetris_fsm

Single-clock Tetris game engine. It holds a 20×10 playfield and one falling tetromino, and applies player moves and a gravity tick. It also merges landed pieces, clears full rows, keeps the score and detects game over. It sits between the debounced button/tick logic and the display renderer, which reads `display_array` directly.

## Interface
- No parameters; dimensions fixed (20 rows × 10 columns).
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `onehuzz` in 1: one-cycle gravity tick (nominally 1 Hz).
- `en_newgame` in 1: pulse; from GAMEOVER, returns to IDLE.
- `start_i` in 1: pulse; from IDLE, begins play.
- `left_i`, `right_i` in 1 each: one-cycle move pulses.
- `rotate_r`, `rotate_l` in 1 each: one-cycle rotate pulses (clockwise / counter-clockwise).
- `speed_up_i` in 1: level; fast drop while high.
- `display_array` out [19:0][9:0]: row-major, row 19 = top, col 0 = left; 1 = occupied.
- `gameover` out 1: high in GAMEOVER.
- `score` out 8: cleared-row count, saturates at 255.
- `speed_mode_o` out 1: registered copy of `speed_up_i`.

## Operation
- States: IDLE, SPAWN, FALL, LAND, CLEAR, GAMEOVER.
- IDLE: board, score and piece cleared. `start_i` → SPAWN.
- Piece index order: 0..6 = I, O, T, S, Z, J, L.
- Piece type counter: reset value 1 (O). It increments mod 7 on each spawn, after the current type is used.
- Active piece: type, rotation 0..3, and anchor (row, col) of the top-left corner of a 4×4 box. Box rows run downward from the anchor.
- SPAWN: load type, rotation 0, anchor (19, 3).
  - If the spawned cells overlap the stack → GAMEOVER.
  - Otherwise → FALL.
- Collision means any cell has col < 0, col > 9 or row < 0, or any cell overlaps the stack.
- FALL handles at most one player action per cycle. Priority: rotate_r > rotate_l > left_i > right_i.
  - Each action is a trial move. It is committed only if the result has no collision; otherwise it is ignored.
- Drop event: `onehuzz` when `speed_mode_o` = 0; every clock when `speed_mode_o` = 1.
  - On a drop event, try row−1. If it collides → LAND, else commit.
  - A drop takes precedence over a player action in the same cycle; the action is dropped.
- LAND: OR the piece cells into the stack → CLEAR.
- CLEAR: scans rows 0..19, one full row per cycle.
  - A full row is removed, rows above shift down one, top row filled with 0, score += 1 (saturating).
  - After removing a row, the same row index is rechecked.
  - When no full rows remain → SPAWN.
- GAMEOVER: board frozen, inputs ignored except `en_newgame` → IDLE.
- `display_array` = stack OR active-piece cells. It is combinational from registered state. Piece cells are shown only in FALL.
- `start_i` outside IDLE and `en_newgame` outside GAMEOVER are ignored.

## Timing
- Reset values:
  - state IDLE;
  - `display_array` all 0, `score` 0, `gameover` 0, `speed_mode_o` 0;
  - piece counter 1.
- `start_i` sampled at edge N → SPAWN at N+1 → FALL at N+2. The piece is visible on `display_array` from N+2.
- A move/rotate pulse at edge K is visible after edge K.
- A landing drop at edge K → LAND at K+1 → CLEAR entered at K+2. CLEAR takes 1 cycle per cleared row plus 1 → SPAWN.
- `gameover` asserts the cycle after the colliding SPAWN.
- Reset mid-game returns immediately to the reset values.

## Structure
- Shared package `tetris_pkg`:
  - state enum;
  - piece-type enum;
  - constants ROWS = 20, COLS = 10, SPAWN_ROW = 19, SPAWN_COL = 3;
  - shape table: 7 types × 4 rotations of 16-bit 4×4 masks, bit [r*4+c] = box row r (downward), column c.
- Natural sub-module: `tetris_collide`. Combinational; inputs stack, type, rotation and anchor; outputs a collision flag and a 20×10 piece mask. It is used for trial moves, spawn and display.

## Test plan
- Reset low, then release, 20 clocks with no inputs → `display_array` all 0, `score` 0, `gameover` 0.
- Pulse `start_i`, then 20 clocks without `onehuzz` → O piece constant at rows 19,18 cols 4,5; all other cells 0.
- After start:
  - `left_i` ×5 → O at cols 0,1; the 5th pulse is ignored.
  - `right_i` ×10 → O at cols 8,9.
- After start, `onehuzz` ×18 → O at rows 1,0. The next tick lands it; a T piece spawns at row 19, and the stack holds the O.
- Preload rows 0 and 1 full except cols 4,5, then land the O there → both rows cleared, `score` = 2, board empty above.
- Stack pieces with `speed_up_i` = 1 until a spawn collides → `gameover` = 1 and the board frozen. Pulse `en_newgame` → IDLE, board 0, `score` 0, `gameover` 0.
